text_console_ctrl: RTL

- Terminal-style writer for the VGA text buffer that the character painter reads.
- Accepts a character stream (CPU store to the console port) and keeps a cursor.
- Writes cells as {color[23:0], 1'b0, char[6:0]}.
- Handles CR, LF, backspace and form feed, plus hardware scroll and full-screen clear by sequencing the buffer's read and write ports.

---
 rtl/text_console_ctrl_pkg.sv | 34 +++
 rtl/console_cursor.sv | 59 +++++
 rtl/text_console_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/text_console_ctrl_pkg.sv
// Shared constants and types for the text console writer: screen geometry,
// cell layout, control codes and the sequencer state encoding.
// Included by text_console_ctrl and console_cursor.
package text_console_ctrl_pkg;

    localparam int TXT_COLS   = 80;
    localparam int TXT_ROWS   = 30;
    localparam int TXT_ADDR_W = 12;

    // Cell layout: {color[31:8], 1'b0, char[6:0]}
    localparam int CELL_COLOR_MSB = 31;
    localparam int CELL_COLOR_LSB = 8;
    localparam int CELL_CHAR_MSB  = 6;
    localparam int CELL_CHAR_LSB  = 0;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SCROLL_COPY = 2'd1,
        SCROLL_CLR  = 2'd2,
        CLEAR       = 2'd3
    } console_state_t;

    function automatic logic [31:0] make_cell(input logic [23:0] color, input logic [7:0] ch);
        return {color, 1'b0, ch[6:0]};
    endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor register pair for the text console: advance, back, newline, CR and home.
// Ports: one-hot-ish op strobes in (priority home > newline > cr > back > advance),
// col/row out plus linear cell address row*COLS+col and edge flags.
module console_cursor
    import text_console_ctrl_pkg::*;
#(
    parameter int COLS = TXT_COLS,
    parameter int ROWS = TXT_ROWS,
    parameter bit WRAP = 1'b0      // newline on the last row wraps to row 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    input  logic                  back,
    input  logic                  newline,
    input  logic                  cr,
    input  logic                  home,
    output logic [6:0]            col,
    output logic [4:0]            row,
    output logic [TXT_ADDR_W-1:0] addr,
    output logic                  last_col,
    output logic                  last_row,
    output logic                  at_origin
);

    assign last_col  = (col == 7'(COLS - 1));
    assign last_row  = (row == 5'(ROWS - 1));
    assign at_origin = (col == 7'd0) && (row == 5'd0);
    assign addr      = TXT_ADDR_W'(row) * TXT_ADDR_W'(COLS) + TXT_ADDR_W'(col);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= 7'd0;
            row <= 5'd0;
        end else if (home) begin
            col <= 7'd0;
            row <= 5'd0;
        end else if (newline) begin
            col <= 7'd0;
            if (!last_row)
                row <= row + 5'd1;
            else if (WRAP)
                row <= 5'd0;
        end else if (cr) begin
            col <= 7'd0;
        end else if (back) begin
            // caller never issues back at the origin
            if (col == 7'd0) begin
                col <= 7'(COLS - 1);
                row <= row - 5'd1;
            end else begin
                col <= col - 7'd1;
            end
        end else if (advance) begin
            col <= col + 7'd1;
        end
    end

endmodule

// File: rtl/text_console_ctrl.sv
// Terminal-style writer for the VGA text buffer: prints chars, handles CR/LF/BS/FF,
// scrolls (TEXT_CONSOLE_SCROLL_EN) or wraps+blanks row 0, and clears the screen.
// Latency: one cycle from accept to write strobe; cmd_ready is low while a fill/copy runs.
// Ports: cmd_* command handshake in; buf_* text-buffer write/read ports; cur_col/cur_row, busy out.
module text_console_ctrl
    import text_console_ctrl_pkg::*;
#(
    parameter int          COLS        = TXT_COLS,
    parameter int          ROWS        = TXT_ROWS,
    parameter logic [23:0] BLANK_COLOR = 24'h000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [7:0]            cmd_char,
    input  logic [23:0]           cmd_color,
    output logic                  buf_we,
    output logic [TXT_ADDR_W-1:0] buf_waddr,
    output logic [31:0]           buf_wdata,
    output logic                  buf_re,
    output logic [TXT_ADDR_W-1:0] buf_raddr,
    input  logic [31:0]           buf_rdata,
    output logic [6:0]            cur_col,
    output logic [4:0]            cur_row,
    output logic                  busy
);

    localparam logic [TXT_ADDR_W-1:0] LAST_CELL  = TXT_ADDR_W'(COLS * ROWS - 1);
    localparam logic [TXT_ADDR_W-1:0] ROW0_LAST  = TXT_ADDR_W'(COLS - 1);
    localparam logic [TXT_ADDR_W-1:0] COPY_LEN   = TXT_ADDR_W'(COLS * (ROWS - 1));
    localparam logic [31:0]           BLANK_CELL = make_cell(BLANK_COLOR, CH_SPACE);

`ifdef TEXT_CONSOLE_SCROLL_EN
    localparam bit WRAP = 1'b0;
`else
    localparam bit WRAP = 1'b1;
`endif

    console_state_t        state;
    logic [TXT_ADDR_W-1:0] cnt;
    logic [TXT_ADDR_W-1:0] fill_last;
    logic                  we_q;
    logic [TXT_ADDR_W-1:0] waddr_q;
    logic [31:0]           wdata_q;

    logic                  accept, printable, is_bs;
    logic                  c_advance, c_back, c_newline, c_cr, c_home;
    logic [TXT_ADDR_W-1:0] cur_addr;
    logic                  last_col, last_row, at_origin;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign printable = (cmd_char >= CH_SPACE) && (cmd_char <= CH_TILDE);
    assign is_bs     = (cmd_char == CH_BS);

    // A printable in the last column turns into a newline instead of a column step.
    assign c_advance = accept && printable && !last_col;
    assign c_newline = accept && ((printable && last_col) || (cmd_char == CH_LF));
    assign c_cr      = accept && (cmd_char == CH_CR);
    assign c_back    = accept && is_bs && !at_origin;
    assign c_home    = accept && (cmd_char == CH_FF);

    console_cursor #(.COLS(COLS), .ROWS(ROWS), .WRAP(WRAP)) u_cursor (
        .clk       (clk),
        .rst       (rst),
        .advance   (c_advance),
        .back      (c_back),
        .newline   (c_newline),
        .cr        (c_cr),
        .home      (c_home),
        .col       (cur_col),
        .row       (cur_row),
        .addr      (cur_addr),
        .last_col  (last_col),
        .last_row  (last_row),
        .at_origin (at_origin)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            fill_last <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (printable) begin
                            we_q    <= 1'b1;
                            waddr_q <= cur_addr;
                            wdata_q <= make_cell(cmd_color, cmd_char);
                        end else if (c_back) begin
                            // cursor moves linearly back one cell
                            we_q    <= 1'b1;
                            waddr_q <= cur_addr - 1'b1;
                            wdata_q <= BLANK_CELL;
                        end
                        if (c_home) begin
                            state     <= CLEAR;
                            cnt       <= '0;
                            fill_last <= LAST_CELL;
                        end else if (c_newline && last_row) begin
`ifdef TEXT_CONSOLE_SCROLL_EN
                            state <= SCROLL_COPY;
                            cnt   <= '0;
`else
                            // cursor wraps to row 0; blank that row
                            state     <= CLEAR;
                            cnt       <= '0;
                            fill_last <= ROW0_LAST;
`endif
                        end
                    end
                end
`ifdef TEXT_CONSOLE_SCROLL_EN
                SCROLL_COPY: begin
                    // read of cell cnt+COLS issued this cycle; the write of
                    // cell cnt-1 uses the data returned for the previous read
                    if (cnt != '0) begin
                        we_q    <= 1'b1;
                        waddr_q <= cnt - 1'b1;
                    end
                    if (cnt == COPY_LEN) begin
                        state     <= SCROLL_CLR;
                        fill_last <= LAST_CELL;  // cnt already points at the last row
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SCROLL_CLR: begin
                    we_q    <= 1'b1;
                    waddr_q <= cnt;
                    wdata_q <= BLANK_CELL;
                    if (cnt == fill_last) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                CLEAR: begin
                    we_q    <= 1'b1;
                    waddr_q <= cnt;
                    wdata_q <= BLANK_CELL;
                    if (cnt == fill_last) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign buf_we    = we_q;
    assign buf_waddr = waddr_q;

`ifdef TEXT_CONSOLE_SCROLL_EN
    logic                  re_q;
    logic [TXT_ADDR_W-1:0] raddr_q;
    logic                  copy_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            re_q     <= 1'b0;
            raddr_q  <= '0;
            copy_sel <= 1'b0;
        end else begin
            re_q     <= (state == SCROLL_COPY) && (cnt != COPY_LEN);
            copy_sel <= (state == SCROLL_COPY) && (cnt != '0);
            if ((state == SCROLL_COPY) && (cnt != COPY_LEN))
                raddr_q <= cnt + TXT_ADDR_W'(COLS);
        end
    end

    // Read data arrives the cycle after buf_re, the same cycle its write is
    // strobed, so copy data is forwarded straight from the read port.
    assign buf_re    = re_q;
    assign buf_raddr = raddr_q;
    assign buf_wdata = copy_sel ? buf_rdata : wdata_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^buf_rdata;
    assign buf_re       = 1'b0;
    assign buf_raddr    = '0;
    assign buf_wdata    = wdata_q;
`endif

endmodule
